// File: rtl/spi_device_rx.sv
// -----------------------------------------------------------------------------
// spi_device_rx
//
// SPI responder-side receiver. Accepts mode-0 (CPOL=0, CPHA=0), MSB-first byte
// frames from an external SPI host, oversampled on clk_i, and buffers completed
// bytes in an RX FIFO that the core drains through a simple device bus.
//
// Optional feature macro: SPI_DEVICE_RX_IRQ_EN
//   defined     : irq_o = registered (!rx_empty | overflow)
//   not defined : irq_o tied low, no interrupt logic
//
// Parameters
//   RX_DEPTH         RX FIFO entries (power of two, 2..256)
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   device_req_i     bus request (never stalled)
//   device_addr_i    byte address, [11:0] decoded
//   device_we_i      write enable
//   device_be_i      byte enables
//   device_wdata_i   write data
//   device_rvalid_o  response valid, one cycle after each request
//   device_rdata_o   read data (0 for writes)
//   sck_i            SPI clock from host (asynchronous)
//   cs_ni            SPI chip select, active-low (asynchronous)
//   mosi_i           SPI serial data from host (asynchronous)
//   irq_o            receive interrupt, level
//
// Register map
//   0x0 RX_DATA  read : {23'b0, valid, byte}, pops head when non-empty & be[0]
//   0x4 STATUS   read : {16'b0, level[7:0], 5'b0, overflow, rx_full, rx_empty}
//                write: be[0] & wdata[2] clears overflow
// -----------------------------------------------------------------------------
module spi_device_rx #(
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        sck_i,
  input  logic        cs_ni,
  input  logic        mosi_i,
  output logic        irq_o
);

  localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  // Level is PW bits wide (up to 9); only the low 8 bits are shown, so a full
  // 256-entry FIFO reads back as level 0 with rx_full set.
  function automatic logic [7:0] level_disp(input logic [PW-1:0] lvl);
    logic [8:0] wide;
    wide = 9'(lvl);
    return wide[7:0];
  endfunction

  // Synchronizers: index 0 is the first stage. sck carries one extra stage
  // for edge detection; cs and mosi share the same depth so they stay aligned
  // with the detected sck edge.
  logic [2:0]    sck_sync_q, sck_sync_d;
  logic [1:0]    cs_sync_q, cs_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;

  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    mem_q [RX_DEPTH];

  logic          sck_rise, cs_sel, mosi_s;
  logic [PW-1:0] level;
  logic          rx_empty, rx_full;
  logic [11:0]   addr;
  logic          rd_data_sel, rd_stat_sel;
  logic          pop, push, byte_done, ovf_set, ovf_clr;
  logic [7:0]    new_byte;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{device_addr_i[31:12], device_be_i[3:1],
                             device_wdata_i[31:3], device_wdata_i[1:0]};

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck_i};
    cs_sync_d   = {cs_sync_q[0], cs_ni};
    mosi_sync_d = {mosi_sync_q[0], mosi_i};

    sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    cs_sel   = ~cs_sync_q[1];
    mosi_s   = mosi_sync_q[1];

    level    = wr_ptr_q - rd_ptr_q;
    rx_empty = (level == '0);
    rx_full  = (level == PW'(RX_DEPTH));

    addr        = device_addr_i[11:0];
    rd_data_sel = device_req_i & ~device_we_i & (addr == 12'h000);
    rd_stat_sel = device_req_i & ~device_we_i & (addr == 12'h004);
    pop         = rd_data_sel & device_be_i[0] & ~rx_empty;
    ovf_clr     = device_req_i & device_we_i & (addr == 12'h004) &
                  device_be_i[0] & device_wdata_i[2];

    new_byte  = {shift_q[6:0], mosi_s};
    byte_done = cs_sel & sck_rise & (bit_cnt_q == 3'd7);
    // A full FIFO still accepts the byte when a pop happens in the same cycle.
    push      = byte_done & (~rx_full | pop);
    ovf_set   = byte_done & rx_full & ~pop;

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (!cs_sel) begin
      // Deselect discards any partial byte.
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shift_d   = new_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);

    rvalid_d = device_req_i;
    rdata_d  = '0;
    if (pop) begin
      rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q[AW-1:0]]};
    end else if (rd_stat_sel) begin
      rdata_d = {16'b0, level_disp(level), 5'b0, overflow_q, rx_full, rx_empty};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // FIFO storage holds data only; pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= new_byte;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;

`ifdef SPI_DEVICE_RX_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ~rx_empty | overflow_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_device_rx.sv
module tb_spi_device_rx;

  localparam int unsigned DEPTH = 16;
`ifdef SPI_DEVICE_RX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        sck, cs_n, mosi;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes the FIFO should hold, plus the sticky overflow flag.
  logic [7:0] mq[$];
  logic       movf;

  logic        rv;
  logic [31:0] rd, ex;

  spi_device_rx #(.RX_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .sck_i          (sck),
    .cs_ni          (cs_n),
    .mosi_i         (mosi),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status();
    int lvl;
    lvl = mq.size();
    return {16'b0, 8'(lvl % 256), 5'b0, movf, (lvl == DEPTH), (lvl == 0)};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else movf = 1'b1;
  endtask

  task automatic model_pop(output logic [31:0] e);
    if (mq.size() == 0) e = 32'h0;
    else e = {23'b0, 1'b1, mq.pop_front()};
  endtask

  // All bus/SPI tasks start and end just after a falling clock edge.
  task automatic bus_read(input logic [11:0] a, output logic v, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = {20'h0, a}; be = 4'hF; wdata = 32'h0;
    @(negedge clk);
    v = rvalid; d = rdata;
    req = 1'b0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] dat,
                           output logic v, output logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = {20'h0, a}; be = 4'hF; wdata = dat;
    @(negedge clk);
    v = rvalid; d = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); movf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", rvalid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0b exp=0", irq); end
    rst = 1'b0;
    mq.delete(); movf = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(12'h004, rv, rd);
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL rst_status_vld got=%0b exp=1", rv); end
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL rst_status got=%h exp=00000001", rd); end
    bus_read(12'h000, rv, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_rxdata got=%h exp=0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq2 got=%0b exp=0", irq); end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    b = 8'hA5;
    cs_low();
    for (int i = 7; i >= 1; i--) spi_bit(b[i]);
    mosi = b[0];
    repeat (4) @(negedge clk);
    sck = 1'b1;
    model_push(b);
    repeat (3) @(negedge clk);
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL latency_status got=%h exp=%h", rd, exp_status()); end
    @(negedge clk);
    sck = 1'b0;
    cs_high();
    model_pop(ex);
    bus_read(12'h000, rv, rd);
    total++; if (rd !== ex || ex !== 32'h1A5) begin bad++; $display("FAIL single_data got=%h exp=%h", rd, ex); end
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL single_status_after got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_partial_frame();
    logic [7:0] junk;
    junk = 8'($urandom);
    cs_low();
    spi_byte(8'h3C); model_push(8'h3C);
    for (int i = 7; i >= 5; i--) spi_bit(junk[i]);
    cs_high();
    cs_low();
    spi_byte(8'hC3); model_push(8'hC3);
    cs_high();
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL partial_status got=%h exp=%h", rd, exp_status()); end
    for (int k = 0; k < 3; k++) begin
      model_pop(ex);
      bus_read(12'h000, rv, rd);
      total++; if (rd !== ex) begin bad++; $display("FAIL partial_data%0d got=%h exp=%h", k, rd, ex); end
    end
  endtask

  task automatic test_regs();
    logic [7:0] b;
    b = 8'($urandom);
    cs_low(); spi_byte(b); model_push(b); cs_high();
    bus_write(12'h000, 32'hFFFF_FFFF, rv, rd);
    total++; if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL write_resp got=%0b/%h exp=1/0", rv, rd); end
    bus_read(12'h008, rv, rd);
    total++; if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped got=%0b/%h exp=1/0", rv, rd); end
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL regs_status got=%h exp=%h", rd, exp_status()); end
    total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL irq_set got=%0b exp=%0b", irq, IRQ_EN); end
    model_pop(ex);
    bus_read(12'h000, rv, rd);
    total++; if (rd !== ex) begin bad++; $display("FAIL regs_data got=%h exp=%h", rd, ex); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%0b exp=0", irq); end
  endtask

  task automatic test_overflow();
    do_reset();
    cs_low();
    for (int k = 0; k < DEPTH + 1; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      spi_byte(b);
      model_push(b);
    end
    cs_high();
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL ovf_status got=%h exp=%h", rd, exp_status()); end
    total++; if (irq !== IRQ_EN) begin bad++; $display("FAIL ovf_irq got=%0b exp=%0b", irq, IRQ_EN); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      model_pop(ex);
      bus_read(12'h000, rv, rd);
      total++; if (rd !== ex) begin bad++; $display("FAIL ovf_data%0d got=%h exp=%h", k, rd, ex); end
    end
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL ovf_sticky got=%h exp=%h", rd, exp_status()); end
    bus_write(12'h004, 32'h4, rv, rd);
    movf = 1'b0;
    total++; if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ovf_clr_resp got=%0b/%h exp=1/0", rv, rd); end
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL ovf_cleared got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] nb;
    do_reset();
    cs_low();
    for (int k = 0; k < DEPTH; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      spi_byte(b);
      model_push(b);
    end
    nb = 8'($urandom);
    for (int i = 7; i >= 1; i--) spi_bit(nb[i]);
    mosi = nb[0];
    repeat (4) @(negedge clk);
    sck = 1'b1;
    // Read request lands on the same clock that stores the completing byte.
    repeat (2) @(negedge clk);
    model_pop(ex);
    bus_read(12'h000, rv, rd);
    model_push(nb);
    total++; if (rd !== ex) begin bad++; $display("FAIL pp_head got=%h exp=%h", rd, ex); end
    repeat (2) @(negedge clk);
    sck = 1'b0;
    cs_high();
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL pp_status got=%h exp=%h", rd, exp_status()); end
    for (int k = 0; k < DEPTH; k++) begin
      model_pop(ex);
      bus_read(12'h000, rv, rd);
      total++; if (rd !== ex) begin bad++; $display("FAIL pp_data%0d got=%h exp=%h", k, rd, ex); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [3];
    do_reset();
    cs_low();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      spi_byte(b);
      model_push(b);
    end
    cs_high();
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got[k] = rdata;
    end
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model_pop(ex);
      total++; if (got[k] !== ex) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, got[k], ex); end
    end
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL b2b_status got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    do_reset();
    cs_low();
    b = 8'($urandom);
    spi_byte(b);
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom));
    req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++; if (rvalid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got=%0b/%h/%0b exp=0/0/0", rvalid, rdata, irq);
    end
    mq.delete(); movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cs_high();
    bus_read(12'h004, rv, rd);
    total++; if (rd !== exp_status()) begin bad++; $display("FAIL midrst_status got=%h exp=%h", rd, exp_status()); end
    b = 8'($urandom);
    cs_low(); spi_byte(b); model_push(b); cs_high();
    model_pop(ex);
    bus_read(12'h000, rv, rd);
    total++; if (rd !== ex) begin bad++; $display("FAIL midrst_data got=%h exp=%h", rd, ex); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; movf = 1'b0;
    test_reset();
    test_single_byte();
    test_partial_frame();
    test_regs();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
